series_adder_ctrl: RTL

//  Sequencer sitting between the CPU register interface and series_adder.
//  CPU loads M operand words of N bits into an internal buffer, then pulses start.

---
 rtl/series_adder_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/series_adder_ctrl.sv
// -----------------------------------------------------------------------------
// series_adder_ctrl
//   Sequencer between a CPU register interface and a bit-serial series_adder.
//   The CPU loads M operand words of N bits, then pulses start. The block
//   clears the adder for one cycle, streams N bit-slices LSB-first (slice k
//   carries bit k of every operand), waits for the adder's result_vld and
//   captures the sum. done pulses for one cycle whenever result/err update.
//
// Optional feature macro: SADD_CTRL_TIMEOUT_EN
//   defined   : WAIT is bounded to TIMEOUT cycles; on expiry err is set, done
//               pulses, result is left unchanged.
//   undefined : WAIT is unbounded and err is constant 0.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/
//   wr_data           operand write port (honoured only while idle)
//   start             one-cycle pulse that begins a summation
//   busy              high from accepted start until done
//   done              one-cycle pulse: result/err updated
//   err               sticky timeout flag, cleared by an accepted start
//   result            last captured sum
//   adder_rst_p       synchronous active-high reset to series_adder
//   adder_data_vld    slice valid to series_adder
//   adder_data        bit-slice to series_adder
//   adder_result_vld  series_adder result valid
//   adder_result      series_adder result
// -----------------------------------------------------------------------------
module series_adder_ctrl #(
  parameter int M = 8,
  parameter int N = 8
`ifdef SADD_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(M)-1:0]     wr_addr,
  input  logic [N-1:0]             wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(M)+N-1:0]   result,
  output logic                     adder_rst_p,
  output logic                     adder_data_vld,
  output logic [M-1:0]             adder_data,
  input  logic                     adder_result_vld,
  input  logic [$clog2(M)+N-1:0]   adder_result
);

  localparam int RW = $clog2(M) + N;
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_FEED  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [M-1:0][N-1:0]     opbuf_q, opbuf_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [RW-1:0]           result_q, result_d;
  logic                    adder_rst_p_q, adder_rst_p_d;
  logic                    adder_data_vld_q, adder_data_vld_d;
  logic [M-1:0]            adder_data_q, adder_data_d;

`ifdef SADD_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic                    err_q, err_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
`endif

  // Gather bit k of every operand word into one M-bit slice.
  function automatic logic [M-1:0] bit_slice(input logic [M-1:0][N-1:0] words,
                                             input logic [KW-1:0]        k);
    logic [M-1:0] s;
    s = {M{1'b0}};
    for (int j = 0; j < M; j++) begin
      s[j] = words[j][k];
    end
    return s;
  endfunction

  // Next-state and next-output logic; outputs are computed for the state being
  // entered so that every output comes straight from a register.
  always_comb begin
    state_d          = state_q;
    opbuf_d          = opbuf_q;
    k_d              = k_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    result_d         = result_q;
    adder_rst_p_d    = 1'b0;
    adder_data_vld_d = 1'b0;
    adder_data_d     = {M{1'b0}};
`ifdef SADD_CTRL_TIMEOUT_EN
    err_d            = err_q;
    tcnt_d           = tcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A write in the same cycle as start lands before FEED reads the buffer.
        if (wr_en) begin
          opbuf_d[wr_addr] = wr_data;
        end else begin
          opbuf_d = opbuf_q;
        end
        if (start) begin
          state_d       = S_CLEAR;
          busy_d        = 1'b1;
          adder_rst_p_d = 1'b1;
`ifdef SADD_CTRL_TIMEOUT_EN
          err_d         = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        state_d          = S_FEED;
        k_d              = {KW{1'b0}};
        adder_data_vld_d = 1'b1;
        adder_data_d     = bit_slice(opbuf_q, {KW{1'b0}});
      end

      S_FEED: begin
        // k_q is the index of the slice currently on adder_data.
        if (k_q == KW'(N - 1)) begin
          state_d = S_WAIT;
`ifdef SADD_CTRL_TIMEOUT_EN
          tcnt_d  = {TW{1'b0}};
`endif
        end else begin
          k_d              = k_q + KW'(1'b1);
          adder_data_vld_d = 1'b1;
          adder_data_d     = bit_slice(opbuf_q, k_q + KW'(1'b1));
        end
      end

      S_WAIT: begin
        if (adder_result_vld) begin
          result_d = adder_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
`ifdef SADD_CTRL_TIMEOUT_EN
          if (tcnt_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            tcnt_d  = tcnt_q + TW'(1'b1);
          end
`else
          state_d = S_WAIT;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, buffer and output registers; reset also holds the adder in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      opbuf_q          <= {(M*N){1'b0}};
      k_q              <= {KW{1'b0}};
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      result_q         <= {RW{1'b0}};
      adder_rst_p_q    <= 1'b1;
      adder_data_vld_q <= 1'b0;
      adder_data_q     <= {M{1'b0}};
    end else begin
      state_q          <= state_d;
      opbuf_q          <= opbuf_d;
      k_q              <= k_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      result_q         <= result_d;
      adder_rst_p_q    <= adder_rst_p_d;
      adder_data_vld_q <= adder_data_vld_d;
      adder_data_q     <= adder_data_d;
    end
  end

`ifdef SADD_CTRL_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      tcnt_q <= {TW{1'b0}};
    end else begin
      err_q  <= err_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign adder_rst_p    = adder_rst_p_q;
  assign adder_data_vld = adder_data_vld_q;
  assign adder_data     = adder_data_q;

endmodule
